spi_frame_target: RTL and testbench
===================================

Name: spi_frame_target

Overview:
- Parametrised SPI target (peripheral-side) front end. Oversamples the external sclk, copi and chipSel on the system clock.
- Shifts one frame of FRAME_BITS bits in both directions in any SPI mode set by CPOL/CPHA.
- Presents received frames on a valid/ready interface to the receive FIFO and takes reply frames from the transmit FIFO on a valid/ready interface.
- Replaces the fixed 66-bit receive/transmit pair; default configuration matches the command processor packet (enable, rd/wr, 32-bit addr, 32-bit data).

Parameters:
- FRAME_BITS, 66: bits per frame, MSB first; legal range 8..128.
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on sclk/copi/chipSel, legal 2..3.

Ports:
- clk  in  1  system clock; sclk must be at most clk/8.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from controller.
- copi  in  1  controller-out data.
- chipSel  in  1  active-low frame select.
- cipo  out  1  target-out data.
- cipo_oe  out  1  high while the synchronised chipSel is low.
- rx_data  out  FRAME_BITS  last received frame.
- rx_valid  out  1  rx_data holds an unconsumed frame.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  FRAME_BITS  reply frame.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  tx_data taken this cycle.
- busy  out  1  state is SHIFT.
- frame_error  out  1  1-cycle pulse: frame ended with bit count not equal to FRAME_BITS.
- overrun  out  1  1-cycle pulse: good frame dropped because rx_valid was still high.
- underrun  out  1  1-cycle pulse: frame started with no tx_valid.

Behaviour:
- Reset values:
  - cipo=0, cipo_oe=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0, all pulses 0.
  - Synchroniser stages: sclk=CPOL, chipSel=1, copi=0.
  - State=RESYNC.
- Synchronisation and edge detection:
  - Inputs pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised stage with one extra flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge is leading if CPHA=0, else trailing. The shift edge is the other one.
- State machine (all transitions use synchronised signals):
  - RESYNC: wait for chipSel=1, then go to IDLE. This prevents joining a frame that was in progress at reset release.
  - IDLE: on chipSel falling edge, go to SHIFT. In the same cycle:
    - Bit counter cleared.
    - If tx_valid=1: tx_shift<=tx_data and tx_ready pulses for 1 cycle.
    - Otherwise: tx_shift<=0 and underrun pulses.
  - SHIFT:
    - On each sample edge while count<FRAME_BITS: rx_shift <= {rx_shift[FRAME_BITS-2:0], copi}.
    - Count increments on every sample edge, saturating at FRAME_BITS+1.
    - Shift edges advance tx_shift left with 0 fill.
    - On chipSel rising edge, go to IDLE and close the frame.
- cipo:
  - cipo = tx_shift[FRAME_BITS-1] while in SHIFT; 0 otherwise.
  - CPHA=0: MSB is valid from the cycle after entering SHIFT. The first shift edge (trailing) presents bit FRAME_BITS-2.
  - CPHA=1: the first leading (shift) edge presents the MSB without shifting; later shift edges shift. A "first" flag tracks this.
- Frame close:
  - count==FRAME_BITS and rx_valid=0: rx_data<=rx_shift and rx_valid<=1 on the next cycle.
  - count==FRAME_BITS and rx_valid=1: overrun pulses; the old rx_data is kept unchanged.
  - Any other count (short, long or zero): frame_error pulses and rx_valid is unaffected.
- rx handshake:
  - rx_valid clears in the cycle after rx_valid&&rx_ready.
  - If a frame closes in the same cycle as a handshake, the new frame is loaded and rx_valid stays 1, with no overrun.
- Latency:
  - Pin sclk edge to internal sample: SYNC_STAGES+1 clk cycles.
  - Pin chipSel rise to rx_valid: SYNC_STAGES+2 cycles.
- Reset mid-frame: all state is discarded, no pulses are issued, and the block returns to RESYNC.
- Sclk edges while in IDLE or RESYNC are ignored.

Test Plan:
- Mode 0, FRAME_BITS=66, tx_data=66'h3_0000_0004_DEAD_BEEF, send copi frame 66'h2_0000_0010_0000_00A5 -> rx_data=66'h2_0000_0010_0000_00A5, rx_valid=1, cipo bit stream equals tx_data MSB first, tx_ready pulsed once.
- All four CPOL/CPHA combinations, FRAME_BITS=8, copi 8'hC3, tx_data 8'h5A -> rx_data=8'hC3 and controller captures 8'h5A in each mode.
- Frames of 65 and 67 bits -> frame_error pulses once each, rx_valid stays 0, rx_data unchanged.
- Two good frames 8'h11 then 8'h22 with rx_ready held 0 -> rx_data=8'h11, overrun pulses once; then rx_ready=1 -> rx_valid drops next cycle.
- Frame with tx_valid=0 -> underrun pulses, cipo=0 for all bits, received data still correct.
- rst asserted after 20 bits with chipSel held low, released, then the frame completes -> no rx_valid and no frame_error; state stays RESYNC until chipSel=1; the next full frame is received correctly.

Source files
------------

// File: rtl/spi_frame_target.sv
// SPI target front end: oversampled sclk/copi/chipSel, one FRAME_BITS frame per chipSel
// window in any CPOL/CPHA mode, valid/ready hand-off to the rx and tx FIFOs.
module spi_frame_target #(
    parameter int FRAME_BITS  = 66,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  copi,
    input  logic                  chipSel,
    output logic                  cipo,
    output logic                  cipo_oe,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int              CW     = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0]   FULL   = CW'(FRAME_BITS);
    localparam logic [CW-1:0]   SAT    = CW'(FRAME_BITS + 1);
    localparam logic [1:0]      RS_MAX = 2'(SYNC_STAGES);

    typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_q, cs_q, copi_q;
    logic                    sclk_d, cs_d;
    logic                    sclk_s, cs_s, copi_s;
    logic                    lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;
    logic [CW-1:0]           count;
    logic [1:0]              rs_cnt;
    logic [FRAME_BITS-1:0]   rx_shift, tx_shift;
    logic                    first, close;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= {SYNC_STAGES{CPOL}};
            cs_q   <= '1;
            copi_q <= '0;
            sclk_d <= CPOL;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], chipSel};
            copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
            sclk_d <= sclk_q[SYNC_STAGES-1];
            cs_d   <= cs_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_q[SYNC_STAGES-1];
    assign cs_s        = cs_q[SYNC_STAGES-1];
    assign copi_s      = copi_q[SYNC_STAGES-1];
    assign lead        = (sclk_s != CPOL) && (sclk_d == CPOL);
    assign trail       = (sclk_s == CPOL) && (sclk_d != CPOL);
    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign cs_fall     = !cs_s && cs_d;
    assign cs_rise     = cs_s && !cs_d;

    assign cipo    = (state == SHIFT) && tx_shift[FRAME_BITS-1];
    assign cipo_oe = !cs_s;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESYNC;
            rs_cnt      <= '0;
            count       <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            first       <= 1'b0;
            close       <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            tx_ready    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            close       <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            // Frame close is evaluated one cycle after the chipSel rise; count is still intact.
            if (close) begin
                if (count == FULL) begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    frame_error <= 1'b1;
                end
            end

            case (state)
                // Synchroniser resets to chipSel=1, so a high level only counts once
                // it has been seen for longer than the chain can hold reset values.
                RESYNC: begin
                    if (cs_s) begin
                        if (rs_cnt == RS_MAX)
                            state <= IDLE;
                        else
                            rs_cnt <= rs_cnt + 2'd1;
                    end else begin
                        rs_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        state <= SHIFT;
                        count <= '0;
                        first <= 1'b1;
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_shift <= '0;
                            underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        close <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            if (count < FULL)
                                rx_shift <= {rx_shift[FRAME_BITS-2:0], copi_s};
                            if (count != SAT)
                                count <= count + CW'(1);
                        end
                        if (shift_edge) begin
                            if (CPHA && first)
                                first <= 1'b0;
                            else
                                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= RESYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_target.sv
// Directed bench: one 66-bit mode-0 target plus four 8-bit targets (one per CPOL/CPHA)
// sharing chipSel/copi, driven by a behavioural SPI controller.
module tb_spi_frame_target;

    localparam logic [65:0] F66  = 66'h2_0000_0010_0000_00A5;
    localparam logic [65:0] T66  = 66'h3_0000_0004_DEAD_BEEF;
    localparam logic [65:0] F66B = 66'h1_2345_6789_ABCD_EF01;

    logic clk = 1'b0;
    logic rst, p, cs, copi, rx_ready, tx_valid;
    logic [65:0] tx66;
    logic [7:0]  tx8;

    logic        cipo66, oe66, rxv66, txr66, busy66, fe66, ov66, un66;
    logic [65:0] rxd66;

    logic       cipo8 [4];
    logic       oe8   [4];
    logic       rxv8  [4];
    logic       txr8  [4];
    logic       busy8 [4];
    logic       fe8   [4];
    logic       ov8   [4];
    logic       un8   [4];
    logic [7:0] rxd8  [4];

    int fe66_n = 0, txr66_n = 0;
    int ov8_n [4] = '{0, 0, 0, 0};
    int un8_n [4] = '{0, 0, 0, 0};

    logic [65:0] cap66;
    logic [7:0]  cap8 [4];
    logic        rst_seen, busy_after_rst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_frame_target #(.FRAME_BITS(66), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u66 (
        .clk(clk), .rst(rst), .sclk(p), .copi(copi), .chipSel(cs),
        .cipo(cipo66), .cipo_oe(oe66), .rx_data(rxd66), .rx_valid(rxv66), .rx_ready(rx_ready),
        .tx_data(tx66), .tx_valid(tx_valid), .tx_ready(txr66), .busy(busy66),
        .frame_error(fe66), .overrun(ov66), .underrun(un66)
    );

    for (genvar g = 0; g < 4; g++) begin : g8
        logic sclk_g;
        assign sclk_g = p ^ (g >= 2);
        spi_frame_target #(.FRAME_BITS(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .SYNC_STAGES(2)) u8 (
            .clk(clk), .rst(rst), .sclk(sclk_g), .copi(copi), .chipSel(cs),
            .cipo(cipo8[g]), .cipo_oe(oe8[g]), .rx_data(rxd8[g]), .rx_valid(rxv8[g]),
            .rx_ready(rx_ready), .tx_data(tx8), .tx_valid(tx_valid), .tx_ready(txr8[g]),
            .busy(busy8[g]), .frame_error(fe8[g]), .overrun(ov8[g]), .underrun(un8[g])
        );
    end

    always @(posedge clk) begin
        if (fe66)  fe66_n  <= fe66_n + 1;
        if (txr66) txr66_n <= txr66_n + 1;
        for (int m = 0; m < 4; m++) begin
            if (ov8[m]) ov8_n[m] <= ov8_n[m] + 1;
            if (un8[m]) un8_n[m] <= un8_n[m] + 1;
        end
    end

    // Controller: half sclk period = 8 clk; copi is held from 4 clk before the
    // leading edge to 4 clk after the trailing edge so every mode samples it cleanly.
    task automatic spi_frame(input int nbits, input logic [127:0] data, input int rst_at);
        cap66 = '0;
        for (int m = 0; m < 4; m++) cap8[m] = '0;
        rst_seen = 1'b0;
        busy_after_rst = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                rst_seen = 1'b1;
            end
            copi = data[nbits-1-i];
            repeat (4) @(negedge clk);
            cap66 = {cap66[64:0], cipo66};
            for (int m = 0; m < 4; m++)
                if (m % 2 == 0) cap8[m] = {cap8[m][6:0], cipo8[m]};
            p = 1'b1;
            repeat (8) @(negedge clk);
            for (int m = 0; m < 4; m++)
                if (m % 2 == 1) cap8[m] = {cap8[m][6:0], cipo8[m]};
            if (rst_seen && busy66) busy_after_rst = 1'b1;
            p = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        copi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; p = 1'b0; cs = 1'b1; copi = 1'b0; rx_ready = 1'b0;
        tx_valid = 1'b1; tx66 = T66; tx8 = 8'h5A;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({cipo66, oe66, rxv66, txr66, busy66, fe66, ov66, un66} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {cipo66, oe66, rxv66, txr66, busy66, fe66, ov66, un66});
        end
        n_checks++;
        if (rxd66 !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h expected 0", rxd66);
        end
        n_checks++;
        if ({rxv8[3], oe8[3], busy8[3]} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_8bit_flags: got %b expected 000", {rxv8[3], oe8[3], busy8[3]});
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy66 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", busy66);
        end
    endtask

    task automatic test_modes();
        spi_frame(8, 128'hC3, -1);
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (rxv8[m] !== 1'b1 || rxd8[m] !== 8'hC3) begin
                n_fail++;
                $display("FAIL mode%0d_rx: got valid=%b data=%h expected valid=1 data=c3",
                         m, rxv8[m], rxd8[m]);
            end
            n_checks++;
            if (cap8[m] !== 8'h5A) begin
                n_fail++;
                $display("FAIL mode%0d_cipo: got %h expected 5a", m, cap8[m]);
            end
        end
        consume();
        n_checks++;
        if (rxv8[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_consume: got %b expected 0", rxv8[2]);
        end
    endtask

    task automatic test_mode0_66();
        int t0;
        t0 = txr66_n;
        spi_frame(66, {62'h0, F66}, -1);
        n_checks++;
        if (rxv66 !== 1'b1 || rxd66 !== F66) begin
            n_fail++;
            $display("FAIL f66_rx: got valid=%b data=%h expected valid=1 data=%h", rxv66, rxd66, F66);
        end
        n_checks++;
        if (cap66 !== T66) begin
            n_fail++;
            $display("FAIL f66_cipo: got %h expected %h", cap66, T66);
        end
        n_checks++;
        if (txr66_n - t0 !== 1) begin
            n_fail++;
            $display("FAIL f66_tx_ready: got %0d pulses expected 1", txr66_n - t0);
        end
        consume();
        n_checks++;
        if (rxv66 !== 1'b0) begin
            n_fail++;
            $display("FAIL f66_consume: got %b expected 0", rxv66);
        end
    endtask

    task automatic test_frame_error();
        int e0;
        e0 = fe66_n;
        spi_frame(65, 128'h1_FFFF_0000_1234_5678, -1);
        n_checks++;
        if (fe66_n - e0 !== 1 || rxv66 !== 1'b0) begin
            n_fail++;
            $display("FAIL short_frame: got errors=%0d valid=%b expected errors=1 valid=0",
                     fe66_n - e0, rxv66);
        end
        spi_frame(67, 128'h5_AAAA_5555_0F0F_F0F0, -1);
        n_checks++;
        if (fe66_n - e0 !== 2 || rxv66 !== 1'b0) begin
            n_fail++;
            $display("FAIL long_frame: got errors=%0d valid=%b expected errors=2 valid=0",
                     fe66_n - e0, rxv66);
        end
        n_checks++;
        if (rxd66 !== F66) begin
            n_fail++;
            $display("FAIL err_rx_data_kept: got %h expected %h", rxd66, F66);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ov8_n[0];
        spi_frame(8, 128'h11, -1);
        spi_frame(8, 128'h22, -1);
        n_checks++;
        if (rxv8[0] !== 1'b1 || rxd8[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_keep: got valid=%b data=%h expected valid=1 data=11",
                     rxv8[0], rxd8[0]);
        end
        n_checks++;
        if (ov8_n[0] - o0 !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d expected 1", ov8_n[0] - o0);
        end
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rxv8[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got %b expected 0", rxv8[0]);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_underrun();
        int u0;
        u0 = un8_n[0];
        tx_valid = 1'b0;
        spi_frame(8, 128'h96, -1);
        n_checks++;
        if (un8_n[0] - u0 !== 1) begin
            n_fail++;
            $display("FAIL underrun_pulse: got %0d expected 1", un8_n[0] - u0);
        end
        n_checks++;
        if (cap8[0] !== 8'h00 || cap8[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL underrun_cipo: got %h/%h expected 00/00", cap8[0], cap8[3]);
        end
        n_checks++;
        if (rxv8[0] !== 1'b1 || rxd8[0] !== 8'h96) begin
            n_fail++;
            $display("FAIL underrun_rx: got valid=%b data=%h expected valid=1 data=96",
                     rxv8[0], rxd8[0]);
        end
        tx_valid = 1'b1;
        consume();
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        e0 = fe66_n;
        spi_frame(66, {62'h0, F66B}, 20);
        n_checks++;
        if (rxv66 !== 1'b0 || fe66_n !== e0) begin
            n_fail++;
            $display("FAIL midrst_no_frame: got valid=%b errors=%0d expected valid=0 errors=0",
                     rxv66, fe66_n - e0);
        end
        n_checks++;
        if (busy_after_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_resync: got busy=%b expected 0", busy_after_rst);
        end
        spi_frame(66, {62'h0, F66B}, -1);
        n_checks++;
        if (rxv66 !== 1'b1 || rxd66 !== F66B) begin
            n_fail++;
            $display("FAIL midrst_next: got valid=%b data=%h expected valid=1 data=%h",
                     rxv66, rxd66, F66B);
        end
        n_checks++;
        if (cap66 !== T66) begin
            n_fail++;
            $display("FAIL midrst_cipo: got %h expected %h", cap66, T66);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_mode0_66();
        test_frame_error();
        test_overrun();
        test_underrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
